// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the write-request record for the register-file write arbiter.
package regfile_write_arbiter_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back requester bundle plus the register file write port it feeds.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W  = regfile_write_arbiter_pkg::ADDR_W
);
  // Requester i transfers on the cycle req_valid[i] && req_ready[i]; it keeps
  // valid, addr slice i and data slice i stable until that cycle. At most one
  // ready bit is high, and ready is a combinational function of valid.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]         bus_w;
  logic [ADDR_W-1:0]         addr_w;
  logic                      en_w;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, bus_w, addr_w, en_w
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, bus_w, addr_w, en_w
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin request/grant; the pointer names the highest-priority requester.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    // No grant while reset is held low, even with requests pending.
    if (found && reset) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (|gnt) begin
      ptr_q <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among write-back units and tracks
// pending-write reservations so decode can stall on RAW/WAW hazards.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W  = regfile_write_arbiter_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  wb,
  input  logic                    sb_set,
  input  logic [ADDR_W-1:0]       sb_set_addr,
  input  logic [ADDR_W-1:0]       chk_addr_a,
  input  logic [ADDR_W-1:0]       chk_addr_b,
  input  logic [ADDR_W-1:0]       chk_addr_d,
  output logic                    hazard,
  output logic [(1<<ADDR_W)-1:0]  busy,
  output logic                    sb_error
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  wr_req_t            sel;
  wr_req_t            wr_q;
  logic               en_q;
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_nxt;
  logic               err_q;
  logic               set_on_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wb.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign wb.req_ready = gnt;

  always_comb begin
    sel.addr = wb.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel.data = wb.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Output stage: address/data hold their last values when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= 1'b0;
      wr_q <= '0;
    end else begin
      en_q <= |gnt;
      if (|gnt) wr_q <= sel;
    end
  end

  assign wb.en_w   = en_q;
  assign wb.addr_w = wr_q.addr;
  assign wb.bus_w  = wr_q.data;

  // Commit clears first, then a same-edge reservation of that register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (en_q)   busy_nxt[wr_q.addr]   = 1'b0;
    if (sb_set) busy_nxt[sb_set_addr] = 1'b1;
  end

  assign set_on_busy = sb_set && busy_q[sb_set_addr] &&
                       !(en_q && (wr_q.addr == sb_set_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (set_on_busy) err_q <= 1'b1;
    end
  end

  assign busy     = busy_q;
  assign sb_error = err_q;
  assign hazard   = busy_q[chk_addr_a] | busy_q[chk_addr_b] | busy_q[chk_addr_d];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write-port scoreboard queue.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int W  = AW + DW;

  logic          clk;
  logic          reset;
  logic          sb_set;
  logic [AW-1:0] sb_set_addr;
  logic [AW-1:0] chk_addr_a;
  logic [AW-1:0] chk_addr_b;
  logic [AW-1:0] chk_addr_d;
  logic          hazard;
  logic [7:0]    busy;
  logic          sb_error;

  regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) wb ();

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .chk_addr_a  (chk_addr_a),
    .chk_addr_b  (chk_addr_b),
    .chk_addr_d  (chk_addr_d),
    .hazard      (hazard),
    .busy        (busy),
    .sb_error    (sb_error)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_last;
  logic [7:0]   m_busy;
  logic         m_err;
  int           m_ptr;
  int           m_gnt;
  int           checks;
  int           errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb.req_addr[i*AW +: AW] = a;
    wb.req_data[i*DW +: DW] = d;
    wb.req_valid[i]         = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last = '0;
    m_busy = '0;
    m_err  = 1'b0;
    m_ptr  = 0;
    m_gnt  = -1;
  endtask

  // Check one cycle at the falling edge, advance the model, end just after the rising edge.
  task automatic tick();
    logic [W-1:0]  e;
    logic [N-1:0]  exp_rdy;
    logic [7:0]    b0;
    logic          clr;
    logic [AW-1:0] clr_a;
    int            g;
    int            idx;
    @(negedge clk);
    clr   = 1'b0;
    clr_a = '0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("en_w", 32'(wb.en_w), 32'd1);
      chk("addr_w", 32'(wb.addr_w), 32'(e[W-1:DW]));
      chk("bus_w", 32'(wb.bus_w), 32'(e[DW-1:0]));
      m_last = e;
      clr    = 1'b1;
      clr_a  = e[W-1:DW];
    end else begin
      chk("en_w_idle", 32'(wb.en_w), 32'd0);
      chk("addr_w_hold", 32'(wb.addr_w), 32'(m_last[W-1:DW]));
      chk("bus_w_hold", 32'(wb.bus_w), 32'(m_last[DW-1:0]));
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("sb_error", 32'(sb_error), 32'(m_err));
    chk("hazard", 32'(hazard), 32'(m_busy[chk_addr_a] | m_busy[chk_addr_b] | m_busy[chk_addr_d]));
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && wb.req_valid[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(wb.req_ready), 32'(exp_rdy));
    m_gnt = g;
    if (g >= 0) begin
      exp_q.push_back({wb.req_addr[g*AW +: AW], wb.req_data[g*DW +: DW]});
      m_ptr = (g + 1) % N;
    end
    b0 = m_busy;
    if (clr) m_busy[clr_a] = 1'b0;
    if (sb_set) begin
      if (b0[sb_set_addr] && !(clr && clr_a == sb_set_addr)) m_err = 1'b1;
      m_busy[sb_set_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    sb_set        = 1'b0;
    sb_set_addr   = '0;
    chk_addr_a    = '0;
    chk_addr_b    = '0;
    chk_addr_d    = '0;
    wb.req_valid  = '0;
    wb.req_addr   = '0;
    wb.req_data   = '0;
    model_reset();

    // reset asserted mid-cycle takes effect without a clock
    #3 reset = 1'b0;
    wb.req_valid = 3'b111;
    #1;
    chk("rst_en_w", 32'(wb.en_w), 32'd0);
    chk("rst_busy", 32'(busy), 32'h00);
    chk("rst_sb_error", 32'(sb_error), 32'd0);
    chk("rst_req_ready", 32'(wb.req_ready), 32'd0);
    wb.req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // single write
    set_req(0, 3'd5, 16'hBEEF);
    tick();
    wb.req_valid = '0;
    tick();
    tick();

    // round-robin with all requesters valid; accepted requester gets new data
    set_req(0, 3'd0, 16'hA000);
    set_req(1, 3'd1, 16'hB100);
    set_req(2, 3'd2, 16'hC200);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (m_gnt >= 0)
        wb.req_data[m_gnt*DW +: DW] = wb.req_data[m_gnt*DW +: DW] + 16'd1;
    end
    wb.req_valid = '0;
    tick();

    // random traffic, each requester holds until accepted
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wb.req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 65535)));
      end
      tick();
      if (m_gnt >= 0) wb.req_valid[m_gnt] = 1'b0;
    end
    while (wb.req_valid != '0 && checks < 100000) begin
      tick();
      if (m_gnt >= 0) wb.req_valid[m_gnt] = 1'b0;
    end
    tick();

    // reserve r3, then requester 1 writes r3
    sb_set      = 1'b1;
    sb_set_addr = 3'd3;
    tick();
    sb_set     = 1'b0;
    chk_addr_a = 3'd3;
    tick();
    set_req(1, 3'd3, 16'h1234);
    tick();
    wb.req_valid = '0;
    tick();
    tick();
    tick();

    // reservation lands on the same edge that r3 commits
    sb_set = 1'b1;
    tick();
    sb_set = 1'b0;
    set_req(0, 3'd3, 16'h3333);
    tick();
    wb.req_valid = '0;
    sb_set       = 1'b1;
    tick();
    sb_set = 1'b0;
    tick();
    set_req(2, 3'd3, 16'h4444);
    tick();
    wb.req_valid = '0;
    tick();
    tick();

    // double reservation of r4 is sticky
    chk_addr_b  = 3'd4;
    sb_set      = 1'b1;
    sb_set_addr = 3'd4;
    tick();
    tick();
    sb_set = 1'b0;
    tick();
    tick();

    // reset while a write is on its way to the register file
    set_req(0, 3'd6, 16'h6666);
    sb_set      = 1'b1;
    sb_set_addr = 3'd5;
    tick();
    wb.req_valid = 3'b111;
    sb_set       = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_en_w", 32'(wb.en_w), 32'd0);
    chk("midrst_addr_w", 32'(wb.addr_w), 32'd0);
    chk("midrst_bus_w", 32'(wb.bus_w), 32'd0);
    chk("midrst_busy", 32'(busy), 32'h00);
    chk("midrst_sb_error", 32'(sb_error), 32'd0);
    chk("midrst_req_ready", 32'(wb.req_ready), 32'd0);
    model_reset();
    wb.req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
